// File: rtl/lpif_phy_tx_sink_if.sv
// LPIF transmit beat bus plus the downstream PHY transmit port of lpif_phy_tx_sink.
// Handshake: a beat transfers on a clock edge where the offering side's valid (lp_irdy / tx_valid) and the taking side's ready (pl_trdy / tx_ready) are both high; valid never waits on ready.
interface lpif_phy_tx_sink_if #(
    parameter int LPIF_BUS_WIDTH = 32
);
    localparam int NB = LPIF_BUS_WIDTH / 8;

    logic                      lp_irdy;
    logic [LPIF_BUS_WIDTH-1:0] lp_data;
    logic [NB-1:0]             lp_valid;
    logic [NB-1:0]             lp_tlp_start;
    logic [NB-1:0]             lp_tlp_end;
    logic [NB-1:0]             lp_dllp_start;
    logic [NB-1:0]             lp_dllp_end;
    logic [NB-1:0]             lp_tlpedb;
    logic                      pl_trdy;

    logic                      tx_valid;
    logic                      tx_ready;
    logic [LPIF_BUS_WIDTH-1:0] tx_data;
    logic [NB-1:0]             tx_byte_valid;
    logic [NB-1:0]             tx_tlp_start;
    logic [NB-1:0]             tx_tlp_end;
    logic [NB-1:0]             tx_dllp_start;
    logic [NB-1:0]             tx_dllp_end;
    logic [NB-1:0]             tx_tlpedb;

    modport master (
        output lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
               lp_dllp_start, lp_dllp_end, lp_tlpedb,
        input  pl_trdy,
        input  tx_valid, tx_data, tx_byte_valid, tx_tlp_start, tx_tlp_end,
               tx_dllp_start, tx_dllp_end, tx_tlpedb,
        output tx_ready
    );

    modport slave (
        input  lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
               lp_dllp_start, lp_dllp_end, lp_tlpedb,
        output pl_trdy,
        output tx_valid, tx_data, tx_byte_valid, tx_tlp_start, tx_tlp_end,
               tx_dllp_start, tx_dllp_end, tx_tlpedb,
        input  tx_ready
    );
endinterface

// File: rtl/lpif_phy_tx_sink.sv
// PHY-side LPIF transmit endpoint: beat FIFO toward the PHY tx pipeline plus the LPIF state handshake.
// Optional framing checker enabled by defining LPIF_FRAMING_CHECK_EN; pl_state_sts doubles as the FSM debug view.
module lpif_phy_tx_sink #(
    parameter int LPIF_BUS_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                lclk,
    input  logic                reset,
    lpif_phy_tx_sink_if.slave   bus,
    input  logic [3:0]          lp_state_req,
    input  logic                lp_force_detect,
    output logic [3:0]          pl_state_sts,
    output logic                pl_linkup,
    input  logic                ltssm_linkup,
    output logic [7:0]          framing_err_cnt
);
    localparam int NB = LPIF_BUS_WIDTH / 8;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = LPIF_BUS_WIDTH + 6 * NB;

    localparam logic [3:0] ST_RESET     = 4'b0000;
    localparam logic [3:0] ST_ACTIVE    = 4'b0001;
    localparam logic [3:0] ST_RETRAIN   = 4'b1011;
    localparam logic [3:0] ST_LINKRESET = 4'b1001;

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [3:0]    state, state_next;
    logic          ltssm_q;
    logic          linkup_q;
    logic          trdy_q;
    logic [AW:0]   count, count_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic          push, pop, flush, linkup_fall;

    assign linkup_fall = ltssm_q & ~ltssm_linkup;

    always_comb begin
        state_next = state;
        if (lp_force_detect) begin
            state_next = ST_RESET;
        end else begin
            case (state)
                ST_RESET: begin
                    if (lp_state_req == ST_ACTIVE && ltssm_linkup) state_next = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (lp_state_req == ST_LINKRESET)
                        state_next = ST_LINKRESET;
                    else if (lp_state_req == ST_RETRAIN || linkup_fall)
                        state_next = ST_RETRAIN;
                end
                ST_RETRAIN: begin
                    if (lp_state_req == ST_LINKRESET)
                        state_next = ST_LINKRESET;
                    else if (ltssm_linkup && lp_state_req != ST_RETRAIN)
                        state_next = ST_ACTIVE;
                end
                ST_LINKRESET: begin
                    if (lp_state_req != ST_LINKRESET) state_next = ST_RESET;
                end
                default: state_next = ST_RESET;
            endcase
        end
    end

    // RESET is only ever entered through a flush, so the FIFO is already empty while there.
    assign flush = (state_next == ST_RESET || state_next == ST_LINKRESET) && (state_next != state);
    assign push  = bus.lp_irdy & trdy_q & (|bus.lp_valid);
    assign pop   = bus.tx_valid & bus.tx_ready;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_ONE;
        else if (!push && pop)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge lclk) begin
        if (reset) begin
            state    <= ST_RESET;
            ltssm_q  <= 1'b0;
            linkup_q <= 1'b0;
            trdy_q   <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_next;
            ltssm_q  <= ltssm_linkup;
            linkup_q <= ltssm_linkup & ~lp_force_detect;
            // Registered ready: drops in the same cycle the state leaves ACTIVE or the FIFO fills.
            trdy_q   <= (state == ST_ACTIVE) && (state_next == ST_ACTIVE) && (count_next < DEPTH_C);
            count    <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge lclk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.lp_data, bus.lp_valid, bus.lp_tlp_start, bus.lp_tlp_end,
                            bus.lp_dllp_start, bus.lp_dllp_end, bus.lp_tlpedb};
        end
    end

    assign pl_state_sts = state;
    assign pl_linkup    = linkup_q;
    assign bus.pl_trdy  = trdy_q;
    assign bus.tx_valid = (count != '0);
    assign {bus.tx_data, bus.tx_byte_valid, bus.tx_tlp_start, bus.tx_tlp_end,
            bus.tx_dllp_start, bus.tx_dllp_end, bus.tx_tlpedb} = bus.tx_valid ? mem[rd_ptr] : '0;

`ifdef LPIF_FRAMING_CHECK_EN
    logic       in_tlp, in_dllp, in_tlp_next, in_dllp_next, beat_err, accepted;
    logic [7:0] err_cnt;

    assign accepted = bus.lp_irdy & trdy_q;

    // Lanes are scanned low to high; an EDB mark closes a TLP just like a normal end.
    always_comb begin
        in_tlp_next  = in_tlp;
        in_dllp_next = in_dllp;
        beat_err     = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (!bus.lp_valid[i]) begin
                if (bus.lp_tlp_start[i] | bus.lp_tlp_end[i] | bus.lp_dllp_start[i] |
                    bus.lp_dllp_end[i] | bus.lp_tlpedb[i])
                    beat_err = 1'b1;
            end else begin
                if (bus.lp_tlp_start[i]) begin
                    if (in_tlp_next | in_dllp_next) beat_err = 1'b1;
                    in_tlp_next = 1'b1;
                end
                if (bus.lp_dllp_start[i]) begin
                    if (in_tlp_next | in_dllp_next) beat_err = 1'b1;
                    in_dllp_next = 1'b1;
                end
                if (bus.lp_tlp_end[i] | bus.lp_tlpedb[i]) begin
                    if (!in_tlp_next) beat_err = 1'b1;
                    in_tlp_next = 1'b0;
                end
                if (bus.lp_dllp_end[i]) begin
                    if (!in_dllp_next) beat_err = 1'b1;
                    in_dllp_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge lclk) begin
        if (reset) begin
            in_tlp  <= 1'b0;
            in_dllp <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (flush) begin
                in_tlp  <= 1'b0;
                in_dllp <= 1'b0;
            end else if (accepted) begin
                in_tlp  <= in_tlp_next;
                in_dllp <= in_dllp_next;
            end
            if (accepted && beat_err && err_cnt != 8'd255) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign framing_err_cnt = err_cnt;
`else
    assign framing_err_cnt = 8'd0;
`endif

endmodule
